// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time and
// delivers (pc, instr) to ID through a registered slot backed by a one-entry skid.
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic        out_valid,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   output logic [1:0]  dbg_state
);

   // Handshake: a request transfers on a cycle with imem_req_valid && imem_req_ready;
   // once raised, valid and addr hold until that transfer or a redirect. Each accepted
   // request returns exactly one imem_rsp_valid pulse, no earlier than the next cycle.
   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic        drop_q, drop_d;
   logic        skid_valid_q, skid_valid_d;
   logic [31:0] skid_pc_q, skid_pc_d;
   logic [31:0] skid_instr_q, skid_instr_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_pc_q, out_pc_d;
   logic [31:0] out_instr_q, out_instr_d;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      fetch_pc_d   = fetch_pc_q;
      drop_d       = drop_q;
      skid_valid_d = skid_valid_q;
      skid_pc_d    = skid_pc_q;
      skid_instr_d = skid_instr_q;
      out_valid_d  = out_valid_q;
      out_pc_d     = out_pc_q;
      out_instr_d  = out_instr_q;

      // ID consumes the slot whenever it is not stalled; refills below override this.
      if (!stall) begin
         out_valid_d = 1'b0;
         out_instr_d = NOP_INSTR;
      end

      if (redirect_valid) begin
         pc_d         = redirect_pc & 32'hFFFF_FFFC;
         out_valid_d  = 1'b0;
         out_instr_d  = NOP_INSTR;
         skid_valid_d = 1'b0;
         if ((state_q == S_WAIT) && !imem_rsp_valid) begin
            drop_d  = 1'b1;
            state_d = S_WAIT;
         end else begin
            drop_d  = 1'b0;
            state_d = S_FETCH;
         end
      end else begin
         case (state_q)
            S_FETCH: begin
               if (imem_req_ready) begin
                  fetch_pc_d = pc_q;
                  pc_d       = pc_q + 32'd4;
                  state_d    = S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem_rsp_valid) begin
                  if (drop_q) begin
                     drop_d  = 1'b0;
                     state_d = S_FETCH;
                  end else if (!out_valid_q || !stall) begin
                     out_valid_d = 1'b1;
                     out_pc_d    = fetch_pc_q;
                     out_instr_d = imem_rsp_data;
                     state_d     = S_FETCH;
                  end else begin
                     skid_valid_d = 1'b1;
                     skid_pc_d    = fetch_pc_q;
                     skid_instr_d = imem_rsp_data;
                     state_d      = S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (!stall) begin
                  out_valid_d  = skid_valid_q;
                  out_pc_d     = skid_pc_q;
                  out_instr_d  = skid_instr_q;
                  skid_valid_d = 1'b0;
                  state_d      = S_FETCH;
               end
            end
            default: state_d = S_FETCH;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_FETCH;
         pc_q         <= RESET_PC;
         fetch_pc_q   <= RESET_PC;
         drop_q       <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_pc_q    <= 32'd0;
         skid_instr_q <= NOP_INSTR;
         out_valid_q  <= 1'b0;
         out_pc_q     <= 32'd0;
         out_instr_q  <= NOP_INSTR;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         fetch_pc_q   <= fetch_pc_d;
         drop_q       <= drop_d;
         skid_valid_q <= skid_valid_d;
         skid_pc_q    <= skid_pc_d;
         skid_instr_q <= skid_instr_d;
         out_valid_q  <= out_valid_d;
         out_pc_q     <= out_pc_d;
         out_instr_q  <= out_instr_d;
      end
   end

   // The redirect gate keeps a request from going out at the old pc in the flush cycle.
   assign imem_req_valid = (state_q == S_FETCH) && !redirect_valid;
   assign imem_req_addr  = pc_q;
   assign out_valid      = out_valid_q;
   assign out_pc         = out_pc_q;
   assign out_instr      = out_instr_q;
   assign dbg_state      = state_q;

endmodule
